// File: rtl/tof_pkg.sv
// Shared types and constants for the ToF poll sequencer.
package tof_pkg;

    localparam int unsigned MAX_SENSORS = 8;
    localparam int unsigned ID_W        = 3;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned REG_W       = 16;
    localparam int unsigned NB_W        = 10;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned RANGE_W     = 16;
    localparam int unsigned CNT_W       = 32;

    localparam logic [REG_W-1:0] REG_I2C_ADDR = 16'h0001;
    localparam logic [REG_W-1:0] REG_RANGE    = 16'h0096;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BOOT_REL,
        ST_BOOT_WAIT,
        ST_ADDR_REQ,
        ST_ADDR_WAIT,
        ST_POLL_REQ,
        ST_POLL_WAIT,
        ST_POLL_OUT,
        ST_GAP
    } tof_seq_state_t;

endpackage

// File: rtl/tof_poll_sequencer_if.sv
// Request/response bundle between the sequencer (master) and I2C_Entity (slave).
interface tof_poll_sequencer_if;
    import tof_pkg::*;

    logic [ADDR_W-1:0] i2c_slave_adress;
    logic [REG_W-1:0]  i2c_reg_address;
    logic              i2c_is_read;
    logic [NB_W-1:0]   i2c_nb_of_bytes;
    logic [BYTE_W-1:0] i2c_data_in;
    logic              i2c_start;
    logic              i2c_ready;
    logic              i2c_error;
    logic [BYTE_W-1:0] i2c_data_out;
    logic              i2c_data_valid;

    modport master (
        output i2c_slave_adress, i2c_reg_address, i2c_is_read, i2c_nb_of_bytes,
               i2c_data_in, i2c_start,
        input  i2c_ready, i2c_error, i2c_data_out, i2c_data_valid
    );

    modport slave (
        input  i2c_slave_adress, i2c_reg_address, i2c_is_read, i2c_nb_of_bytes,
               i2c_data_in, i2c_start,
        output i2c_ready, i2c_error, i2c_data_out, i2c_data_valid
    );

endinterface

// File: rtl/tof_delay_counter.sv
// Loadable down-counter; done while the count sits at zero.
module tof_delay_counter
    import tof_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/tof_poll_sequencer.sv
// Boots up to 8 ToF sensors one at a time, re-addresses them, then round-robin
// polls their 16-bit range over I2C_Entity.
// Optional macro TOF_TIMEOUT_EN: per-transaction watchdog in the WAIT states.
// i_reset is asynchronous, active-low.
module tof_poll_sequencer
    import tof_pkg::*;
#(
    parameter int unsigned       NUM_SENSORS  = 8,
    parameter logic [ADDR_W-1:0] DEFAULT_ADDR = 7'h29,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 7'h30,
    parameter int unsigned       BOOT_CYCLES  = 100000,
    parameter int unsigned       GAP_CYCLES   = 1000
`ifdef TOF_TIMEOUT_EN
   ,parameter int unsigned       TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    tof_poll_sequencer_if.master   i2c,
    output logic [MAX_SENSORS-1:0] o_tof_xshut,
    output logic [RANGE_W-1:0]     o_range_data,
    output logic [ID_W-1:0]        o_range_id,
    output logic                   o_range_valid,
    output logic [MAX_SENSORS-1:0] o_sensor_error,
    output logic                   o_boot_done
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_SENSORS - 1);

    tof_seq_state_t          r_state;
    tof_seq_state_t          w_state_nxt;
    logic [ID_W-1:0]         r_idx;
    logic [MAX_SENSORS-1:0]  r_xshut;
    logic [MAX_SENSORS-1:0]  r_sensor_error;
    logic                    r_boot_done;
    logic                    r_busy_seen;
    logic                    r_txn_err;
    logic [1:0]              r_byte_cnt;
    logic [RANGE_W-1:0]      r_rx;
    logic [RANGE_W-1:0]      r_range_data;
    logic [ID_W-1:0]         r_range_id;
    logic                    r_range_valid;
    logic                    r_start;
    logic [ADDR_W-1:0]       r_slave;
    logic [REG_W-1:0]        r_reg;
    logic                    r_is_read;
    logic [NB_W-1:0]         r_nb;
    logic [BYTE_W-1:0]       r_data_in;

    logic                    w_cnt_ld;
    logic [CNT_W-1:0]        w_cnt_val;
    logic                    w_cnt_done_c;
    logic                    w_in_wait;
    logic                    w_timeout;
    logic                    w_fail;
    logic                    w_ok;
    logic                    w_fire_wr;
    logic                    w_fire_rd;
    logic                    w_wait_end;
    logic                    w_idx_adv;
    logic                    w_boot_fin;
    logic                    w_xshut_set;
    logic                    w_publish;

    // One counter serves boot delay, inter-poll gap and the watchdog.
    tof_delay_counter u_delay (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_cnt_ld),
        .i_load_val (w_cnt_val),
        .o_done_c   (w_cnt_done_c)
    );

    assign w_in_wait = (r_state == ST_ADDR_WAIT) || (r_state == ST_POLL_WAIT);
`ifdef TOF_TIMEOUT_EN
    assign w_timeout = w_in_wait && w_cnt_done_c;
`else
    assign w_timeout = 1'b0;
`endif
    assign w_fail = i2c.i2c_error || w_timeout;
    assign w_ok   = i2c.i2c_ready && r_busy_seen;

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_ld    = 1'b0;
        w_cnt_val   = '0;
        w_fire_wr   = 1'b0;
        w_fire_rd   = 1'b0;
        w_wait_end  = 1'b0;
        w_idx_adv   = 1'b0;
        w_boot_fin  = 1'b0;
        w_xshut_set = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_nxt = r_boot_done ? ST_POLL_REQ : ST_BOOT_REL;
            end
            ST_BOOT_REL: begin
                w_xshut_set = 1'b1;
                w_cnt_ld    = 1'b1;
                w_cnt_val   = CNT_W'(BOOT_CYCLES);
                w_state_nxt = ST_BOOT_WAIT;
            end
            ST_BOOT_WAIT: begin
                if (!i_enable)         w_state_nxt = ST_IDLE;
                else if (w_cnt_done_c) w_state_nxt = ST_ADDR_REQ;
            end
            ST_ADDR_REQ: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (i2c.i2c_ready) begin
                    w_fire_wr   = 1'b1;
`ifdef TOF_TIMEOUT_EN
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = CNT_W'(TIMEOUT_CYCLES);
`endif
                    w_state_nxt = ST_ADDR_WAIT;
                end
            end
            ST_ADDR_WAIT: begin
                if (w_fail || w_ok) begin
                    w_wait_end = 1'b1;
                    w_idx_adv  = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_boot_fin  = 1'b1;
                        w_state_nxt = i_enable ? ST_POLL_REQ : ST_IDLE;
                    end else begin
                        w_state_nxt = i_enable ? ST_BOOT_REL : ST_IDLE;
                    end
                end
            end
            ST_POLL_REQ: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (i2c.i2c_ready) begin
                    w_fire_rd   = 1'b1;
`ifdef TOF_TIMEOUT_EN
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = CNT_W'(TIMEOUT_CYCLES);
`endif
                    w_state_nxt = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                if (w_fail || w_ok) begin
                    w_wait_end  = 1'b1;
                    w_state_nxt = ST_POLL_OUT;
                end
            end
            ST_POLL_OUT: begin
                w_publish   = (r_byte_cnt == 2'd2) && !r_txn_err;
                w_idx_adv   = 1'b1;
                w_cnt_ld    = 1'b1;
                w_cnt_val   = CNT_W'(GAP_CYCLES);
                w_state_nxt = i_enable ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (!i_enable)         w_state_nxt = ST_IDLE;
                else if (w_cnt_done_c) w_state_nxt = ST_POLL_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencing datapath: sensor index, xshut, boot flag, error flags.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_idx          <= '0;
            r_xshut        <= '0;
            r_boot_done    <= 1'b0;
            r_sensor_error <= '0;
        end else begin
            if (w_xshut_set) r_xshut[r_idx] <= 1'b1;
            if (w_idx_adv)   r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + ID_W'(1);
            if (w_boot_fin)  r_boot_done <= 1'b1;
            if (w_wait_end && w_fail) r_sensor_error[r_idx] <= 1'b1;
        end
    end

    // Request fields latched at start and held until the next start.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_start   <= 1'b0;
            r_slave   <= '0;
            r_reg     <= '0;
            r_is_read <= 1'b0;
            r_nb      <= '0;
            r_data_in <= '0;
        end else begin
            r_start <= w_fire_wr || w_fire_rd;
            if (w_fire_wr) begin
                r_slave   <= DEFAULT_ADDR;
                r_reg     <= REG_I2C_ADDR;
                r_is_read <= 1'b0;
                r_nb      <= NB_W'(1);
                r_data_in <= BYTE_W'(BASE_ADDR + ADDR_W'(r_idx));
            end else if (w_fire_rd) begin
                r_slave   <= BASE_ADDR + ADDR_W'(r_idx);
                r_reg     <= REG_RANGE;
                r_is_read <= 1'b1;
                r_nb      <= NB_W'(2);
                r_data_in <= '0;
            end
        end
    end

    // Transaction tracking: busy-seen, error, received byte capture.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_busy_seen <= 1'b0;
            r_txn_err   <= 1'b0;
            r_byte_cnt  <= '0;
            r_rx        <= '0;
        end else if (w_fire_wr || w_fire_rd) begin
            r_busy_seen <= 1'b0;
            r_txn_err   <= 1'b0;
            r_byte_cnt  <= '0;
        end else if (w_in_wait) begin
            if (!i2c.i2c_ready) r_busy_seen <= 1'b1;
            if (w_fail)         r_txn_err   <= 1'b1;
            if ((r_state == ST_POLL_WAIT) && i2c.i2c_data_valid && (r_byte_cnt != 2'd2)) begin
                if (r_byte_cnt == 2'd0) r_rx[15:8] <= i2c.i2c_data_out;
                else                    r_rx[7:0]  <= i2c.i2c_data_out;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    // Range output; updated only when a clean 2-byte read completes.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_range_data  <= '0;
            r_range_id    <= '0;
            r_range_valid <= 1'b0;
        end else begin
            r_range_valid <= w_publish;
            if (w_publish) begin
                r_range_data <= r_rx;
                r_range_id   <= r_idx;
            end
        end
    end

    assign i2c.i2c_start        = r_start;
    assign i2c.i2c_slave_adress = r_slave;
    assign i2c.i2c_reg_address  = r_reg;
    assign i2c.i2c_is_read      = r_is_read;
    assign i2c.i2c_nb_of_bytes  = r_nb;
    assign i2c.i2c_data_in      = r_data_in;
    assign o_tof_xshut          = r_xshut;
    assign o_range_data         = r_range_data;
    assign o_range_id           = r_range_id;
    assign o_range_valid        = r_range_valid;
    assign o_sensor_error       = r_sensor_error;
    assign o_boot_done          = r_boot_done;

endmodule

// File: tb/tb_tof_poll_sequencer.sv
// Scoreboard bench for tof_poll_sequencer with a behavioural I2C_Entity model.
module tb_tof_poll_sequencer;
    import tof_pkg::*;

    localparam int unsigned BOOT_C    = 20;
    localparam int unsigned GAP_C     = 10;
    localparam int unsigned TIMEOUT_C = 50;
    localparam int unsigned HANG_C    = TIMEOUT_C + 30;

    // Sensor i read response bytes (byte0 in B0_TBL[8*i+:8]) and NACK mask.
    localparam logic [63:0] B0_TBL = 64'hBC9A_7856_0134_2210;
    localparam logic [63:0] B1_TBL = 64'h0807_0605_2C03_0201;
    localparam logic [7:0]  NACK_MASK = 8'h20;

    typedef struct packed {
        logic [7:0]  xshut;
        logic [6:0]  slave;
        logic [15:0] rega;
        logic        is_read;
        logic [9:0]  nb;
        logic [7:0]  data;
    } req_t;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  id;
    } rng_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  xshut;
    logic [15:0] range_data;
    logic [2:0]  range_id;
    logic        range_valid;
    logic [7:0]  sensor_error;
    logic        boot_done;
    logic        hang_req;

    int checks;
    int errors;
    req_t exp_req[$];
    rng_t exp_rng[$];

    tof_poll_sequencer_if bus();

    tof_poll_sequencer #(
        .NUM_SENSORS  (8),
        .DEFAULT_ADDR (7'h29),
        .BASE_ADDR    (7'h30),
        .BOOT_CYCLES  (BOOT_C),
        .GAP_CYCLES   (GAP_C)
`ifdef TOF_TIMEOUT_EN
       ,.TIMEOUT_CYCLES (TIMEOUT_C)
`endif
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_enable       (enable),
        .i2c            (bus),
        .o_tof_xshut    (xshut),
        .o_range_data   (range_data),
        .o_range_id     (range_id),
        .o_range_valid  (range_valid),
        .o_sensor_error (sensor_error),
        .o_boot_done    (boot_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural I2C_Entity: ready drops after start, reads stream two bytes.
    initial begin
        logic [6:0] m_slave;
        logic       m_rd;
        logic       m_hang_used;
        int         s;
        m_hang_used = 1'b0;
        bus.i2c_ready      = 1'b1;
        bus.i2c_error      = 1'b0;
        bus.i2c_data_valid = 1'b0;
        bus.i2c_data_out   = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.i2c_start) begin
                m_slave = bus.i2c_slave_adress;
                m_rd    = bus.i2c_is_read;
                bus.i2c_ready = 1'b0;
                if (hang_req && !m_hang_used) begin
                    m_hang_used = 1'b1;
                    repeat (HANG_C) @(posedge clk);
                    #1 bus.i2c_ready = 1'b1;
                end else begin
                    repeat (3) @(posedge clk);
                    #1;
                    s = int'(m_slave) - 'h30;
                    if (m_rd && NACK_MASK[s[2:0]]) begin
                        bus.i2c_error = 1'b1;
                        bus.i2c_ready = 1'b1;
                        @(posedge clk); #1;
                        bus.i2c_error = 1'b0;
                    end else begin
                        if (m_rd) begin
                            for (int b = 0; b < 2; b++) begin
                                bus.i2c_data_valid = 1'b1;
                                bus.i2c_data_out   = (b == 0) ? B0_TBL[8*s[2:0] +: 8] : B1_TBL[8*s[2:0] +: 8];
                                @(posedge clk); #1;
                                bus.i2c_data_valid = 1'b0;
                                @(posedge clk); #1;
                            end
                        end
                        bus.i2c_ready = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected transactions whenever the DUT issues one.
    task automatic monitor();
        req_t a_req;
        req_t e_req;
        rng_t a_rng;
        rng_t e_rng;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.i2c_start) begin
                    a_req = '{xshut, bus.i2c_slave_adress, bus.i2c_reg_address,
                              bus.i2c_is_read, bus.i2c_nb_of_bytes, bus.i2c_data_in};
                    checks++;
                    if (exp_req.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: got %h expected none", a_req);
                    end else begin
                        e_req = exp_req.pop_front();
                        if (a_req !== e_req) begin
                            errors++;
                            $display("FAIL req: got %h expected %h", a_req, e_req);
                        end
                    end
                end
                if (range_valid) begin
                    a_rng = '{range_data, range_id};
                    checks++;
                    if (exp_rng.size() == 0) begin
                        errors++;
                        $display("FAIL range_unexpected: got %h expected none", a_rng);
                    end else begin
                        e_rng = exp_rng.pop_front();
                        if (a_rng !== e_rng) begin
                            errors++;
                            $display("FAIL range: got %h expected %h", a_rng, e_rng);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_start(input logic [6:0] slave, input logic [7:0] data, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk); #1;
            if (bus.i2c_start && bus.i2c_slave_adress == slave && bus.i2c_data_in == data) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_start_%h: got no start in %0d cycles expected start", slave, budget);
        end
    endtask

    task automatic push_boot();
        logic [7:0] xs;
        xs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            xs[i] = 1'b1;
            exp_req.push_back('{xs, 7'h29, 16'h0001, 1'b0, 10'd1, 8'(8'h30 + i)});
        end
    endtask

    task automatic push_poll(input int id, input bit with_range);
        exp_req.push_back('{8'hFF, 7'(7'h30 + id), 16'h0096, 1'b1, 10'd2, 8'h00});
        if (with_range && !NACK_MASK[id])
            exp_rng.push_back('{{B0_TBL[8*id +: 8], B1_TBL[8*id +: 8]}, 3'(id)});
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_xshut"},   32'(xshut), 32'h0);
        check_val({tag, "_start"},   32'(bus.i2c_start), 32'h0);
        check_val({tag, "_rdata"},   32'(range_data), 32'h0);
        check_val({tag, "_rid"},     32'(range_id), 32'h0);
        check_val({tag, "_rvalid"},  32'(range_valid), 32'h0);
        check_val({tag, "_serr"},    32'(sensor_error), 32'h0);
        check_val({tag, "_bootdn"},  32'(boot_done), 32'h0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        hang_req = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // Boot all eight, then one poll round; sensor 5 NACKs.
        push_boot();
        for (int i = 0; i < 8; i++) push_poll(i, 1'b1);
        @(posedge clk); #1 enable = 1'b1;
        wait_start(7'h37, 8'h00, 5000);
        enable = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check_val("serr_nack", 32'(sensor_error), 32'h20);
        check_val("boot_done", 32'(boot_done), 32'h1);
        check_val("xshut_all", 32'(xshut), 32'hFF);
        check_val("req_q_empty1", 32'(exp_req.size()), 32'h0);
        check_val("rng_q_empty1", 32'(exp_rng.size()), 32'h0);

        // Re-enable resumes at sensor 0 without re-boot; reset mid-read of sensor 1.
        push_poll(0, 1'b1);
        push_poll(1, 1'b0);
        enable = 1'b1;
        wait_start(7'h31, 8'h00, 1000);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_val("req_q_empty2", 32'(exp_req.size()), 32'h0);
        check_val("rng_q_empty2", 32'(exp_rng.size()), 32'h0);
        check_val("boot_after_rst", 32'(boot_done), 32'h0);

`ifdef TOF_TIMEOUT_EN
        // First address write hangs past the watchdog; boot continues.
        hang_req = 1'b1;
        push_boot();
        enable = 1'b1;
        wait_start(7'h29, 8'h37, 4000);
        enable = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check_val("serr_timeout", 32'(sensor_error), 32'h01);
        check_val("boot_done_to", 32'(boot_done), 32'h1);
        check_val("req_q_empty3", 32'(exp_req.size()), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
